// File: rtl/dp_floating_divider_pkg.sv
// Shared definitions for the binary64 divider: field widths, bias, canonical NaN,
// controller states and operand classes.
package dp_floating_divider_pkg;

    localparam int EXP_W = 11;
    localparam int MAN_W = 52;
    localparam int BIAS  = 1023;

    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        DIV,
        ROUND
    } state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

endpackage

// File: rtl/dp_floating_divider_classify.sv
// Combinational unpack of a binary64 word: sign, exponent, significand with hidden bit,
// and operand class. Denormals are flushed to a signed zero.
module dp_fp_classify
    import dp_floating_divider_pkg::*;
(
    input  logic [63:0]      word,
    output logic             sign,
    output logic [EXP_W-1:0] expo,
    output logic [MAN_W:0]   man,
    output logic [1:0]       cls
);

    always_comb begin
        sign = word[63];
        expo = word[62:52];
        man  = {1'b1, word[51:0]};
        cls  = NORM;
        if (word[62:52] == '0) begin
            expo = '0;
            man  = '0;
            cls  = ZERO;
        end else if (word[62:52] == '1) begin
            cls = (word[51:0] == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/dp_floating_divider.sv
// Multi-cycle IEEE-754 binary64 divider: radix-2 restoring division of the significands,
// round-to-nearest-even, flush-to-zero on denormal inputs and underflowing results.
module dp_floating_divider
    import dp_floating_divider_pkg::*;
#(
    parameter int DIV_ITERS = 55
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        start,
    output logic        ready,
    output logic [63:0] quo,
    output logic        valid,
    output logic [3:0]  flags
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);
    localparam int SIG_W = MAN_W + 1;

    state_t state, next_state;

    logic [63:0]       ra, rb;
    logic              sign_a, sign_b;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [SIG_W-1:0]  man_a, man_b;
    logic [1:0]        cls_a_raw, cls_b_raw;
    fp_class_t         cls_a, cls_b;

    logic [CNT_W-1:0]     cnt;
    logic                 sign_r;
    logic signed [12:0]   exp_r;
    logic [SIG_W:0]       rem;
    logic [SIG_W-1:0]     dvsr;
    logic [DIV_ITERS-1:0] q;
    logic                 special_r;
    logic [63:0]          spec_quo_r;
    logic [3:0]           spec_flags_r;

    dp_fp_classify u_cls_a (
        .word (ra),
        .sign (sign_a),
        .expo (exp_a),
        .man  (man_a),
        .cls  (cls_a_raw)
    );

    dp_fp_classify u_cls_b (
        .word (rb),
        .sign (sign_b),
        .expo (exp_b),
        .man  (man_b),
        .cls  (cls_b_raw)
    );

    assign cls_a = fp_class_t'(cls_a_raw);
    assign cls_b = fp_class_t'(cls_b_raw);

    // Unpack stage: result sign, pre-shift decision, biased exponent and special outcomes.
    logic               pre, sign_n, spec_hit;
    logic signed [12:0] exp_n;
    logic [63:0]        spec_quo;
    logic [3:0]         spec_flags;

    always_comb begin
        sign_n     = sign_a ^ sign_b;
        pre        = man_a < man_b;
        exp_n      = 13'({2'b00, exp_a}) - 13'({2'b00, exp_b}) + 13'(BIAS) - 13'(pre);
        spec_hit   = 1'b1;
        spec_quo   = '0;
        spec_flags = '0;
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
            spec_quo   = QNAN;
            spec_flags = 4'b1000;
        end else if (cls_a == INF) begin
            spec_quo = {sign_n, 11'h7FF, 52'd0};
        end else if (cls_b == INF || cls_a == ZERO) begin
            spec_quo = {sign_n, 63'd0};
        end else if (cls_b == ZERO) begin
            spec_quo   = {sign_n, 11'h7FF, 52'd0};
            spec_flags = 4'b0100;
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic           ge;
    logic [SIG_W:0] rem_sub;

    assign ge      = rem >= {1'b0, dvsr};
    assign rem_sub = ge ? rem - {1'b0, dvsr} : rem;

    // Rounding: sum[SIG_W:SIG_W-1] is 2'b01 normally and 2'b10 on carry-out, so it
    // doubles as the exponent increment (minus one).
    logic [SIG_W-1:0]   sig;
    logic               guard, tail, up;
    logic [SIG_W:0]     sum;
    logic signed [12:0] exp_fin;

    assign sig     = q[DIV_ITERS-1 -: SIG_W];
    assign guard   = q[DIV_ITERS-SIG_W-1];
    assign tail    = (|q[DIV_ITERS-SIG_W-2:0]) | (|rem);
    assign up      = guard & (tail | sig[0]);
    assign sum     = {1'b0, sig} + {{SIG_W{1'b0}}, up};
    assign exp_fin = exp_r + 13'(sum[SIG_W:SIG_W-1]) - 13'sd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = UNPACK;
            UNPACK:  next_state = DIV;
            DIV:     if (cnt == CNT_W'(DIV_ITERS - 1)) next_state = ROUND;
            ROUND:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ra           <= '0;
            rb           <= '0;
            cnt          <= '0;
            sign_r       <= 1'b0;
            exp_r        <= '0;
            rem          <= '0;
            dvsr         <= '0;
            q            <= '0;
            special_r    <= 1'b0;
            spec_quo_r   <= '0;
            spec_flags_r <= '0;
            quo          <= '0;
            flags        <= '0;
            valid        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra <= a;
                        rb <= b;
                    end
                end
                UNPACK: begin
                    sign_r       <= sign_n;
                    exp_r        <= exp_n;
                    rem          <= pre ? {man_a, 1'b0} : {1'b0, man_a};
                    dvsr         <= man_b;
                    q            <= '0;
                    cnt          <= '0;
                    special_r    <= spec_hit;
                    spec_quo_r   <= spec_quo;
                    spec_flags_r <= spec_flags;
                end
                DIV: begin
                    q   <= {q[DIV_ITERS-2:0], ge};
                    rem <= rem_sub << 1;
                    cnt <= cnt + CNT_W'(1);
                end
                ROUND: begin
                    valid <= 1'b1;
                    cnt   <= '0;
                    if (special_r) begin
                        quo   <= spec_quo_r;
                        flags <= spec_flags_r;
                    end else if (exp_fin >= 13'sd2047) begin
                        quo   <= {sign_r, 11'h7FF, 52'd0};
                        flags <= 4'b0010;
                    end else if (exp_fin <= 13'sd0) begin
                        quo   <= {sign_r, 63'd0};
                        flags <= 4'b0001;
                    end else begin
                        quo   <= {sign_r, exp_fin[10:0], sum[MAN_W-1:0]};
                        flags <= 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_floating_divider.sv
// Self-checking bench for dp_floating_divider: directed special/boundary cases, protocol
// checks, and random operands against a real-arithmetic reference model.
module tb_dp_floating_divider;

    logic        clk   = 1'b0;
    logic        nrst  = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a     = '0;
    logic [63:0] b     = '0;
    logic        ready, valid;
    logic [63:0] quo;
    logic [3:0]  flags;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dp_floating_divider #(.DIV_ITERS(55)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .a     (a),
        .b     (b),
        .start (start),
        .ready (ready),
        .quo   (quo),
        .valid (valid),
        .flags (flags)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference: IEEE rules for specials, simulator real division for finite operands,
    // with flush-to-zero on denormal inputs and results.
    function automatic void refDiv(input logic [63:0] x, input logic [63:0] y,
                                   output logic [63:0] rq, output logic [3:0] rf);
        logic xzero, yzero, xinf, yinf, xnan, ynan, s;
        logic [63:0] qb;
        real r;
        xzero = (x[62:52] == 11'd0);
        yzero = (y[62:52] == 11'd0);
        xinf  = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
        yinf  = (y[62:52] == 11'h7FF) && (y[51:0] == 52'd0);
        xnan  = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
        ynan  = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
        s     = x[63] ^ y[63];
        rf    = 4'b0000;
        if (xnan || ynan || (xzero && yzero) || (xinf && yinf)) begin
            rq = 64'h7FF8000000000000;
            rf = 4'b1000;
        end else if (xinf) begin
            rq = {s, 11'h7FF, 52'd0};
        end else if (yinf || xzero) begin
            rq = {s, 63'd0};
        end else if (yzero) begin
            rq = {s, 11'h7FF, 52'd0};
            rf = 4'b0100;
        end else begin
            r  = $bitstoreal(x) / $bitstoreal(y);
            qb = $realtobits(r);
            if (qb[62:52] == 11'h7FF) begin
                rq = {s, 11'h7FF, 52'd0};
                rf = 4'b0010;
            end else if (qb[62:52] == 11'd0) begin
                rq = {s, 63'd0};
                rf = 4'b0001;
            end else begin
                rq = qb;
            end
        end
    endfunction

    function automatic logic [63:0] randNormal();
        logic [10:0] e;
        logic [51:0] f;
        e = 11'(923 + $urandom_range(0, 200));
        f = {20'($urandom), 32'($urandom)};
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    function automatic logic [63:0] randAny();
        logic [63:0] v;
        v = randNormal();
        case ($urandom_range(0, 4))
            1: v[62:0] = '0;
            2: begin v[62:52] = '0; v[0] = 1'b1; end
            3: begin v[62:52] = '1; v[51:0] = '0; end
            4: begin v[62:52] = '1; v[51] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    // Waits for ready, presents operands and start, and returns just after edge E0.
    task automatic applyStimulus(input logic [63:0] x, input logic [63:0] y);
        int waited = 0;
        @(negedge clk);
        while (!ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_start", {63'd0, ready}, 64'd1);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_busy", {63'd0, ready}, 64'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges from E0 (edge 1) until valid is seen; 0 means it never came.
    task automatic waitResult(output int edges);
        edges = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (valid) return;
        end
        edges = 0;
    endtask

    task automatic runOp(input string tag, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] eq, input logic [3:0] ef);
        int edges;
        applyStimulus(x, y);
        waitResult(edges);
        checkOutput({tag, "_latency"}, 64'(edges), 64'd58);
        checkOutput({tag, "_quo"}, quo, eq);
        checkOutput({tag, "_flags"}, 64'(flags), 64'(ef));
        checkOutput({tag, "_ready_at_valid"}, {63'd0, ready}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_pulse"}, {63'd0, valid}, 64'd0);
        checkOutput({tag, "_quo_hold"}, quo, eq);
    endtask

    task automatic runRandom(input string tag, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] eq;
        logic [3:0]  ef;
        refDiv(x, y, eq, ef);
        runOp(tag, x, y, eq, ef);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vcount;
        int edges;
        logic [63:0] first_quo;

        #1 nrst = 1'b0;
        #3;
        checkOutput("reset_ready", {63'd0, ready}, 64'd1);
        checkOutput("reset_valid", {63'd0, valid}, 64'd0);
        checkOutput("reset_quo", quo, 64'd0);
        checkOutput("reset_flags", 64'(flags), 64'd0);
        #8 nrst = 1'b1;

        runOp("div12p5",   64'h4029000000000000, 64'h4004000000000000, 64'h4014000000000000, 4'b0000);
        runOp("third",     64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 4'b0000);
        runOp("divzero",   64'h4018000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 4'b0100);
        runOp("zero_zero", 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b1000);
        runOp("overflow",  64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 4'b0010);
        runOp("underflow", 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 4'b0001);
        runOp("negative",  64'hC029000000000000, 64'h4004000000000000, 64'hC014000000000000, 4'b0000);
        runOp("inf_fin",   64'h7FF0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 4'b0000);
        runOp("fin_inf",   64'h4000000000000000, 64'hFFF0000000000000, 64'h8000000000000000, 4'b0000);
        runOp("zero_fin",  64'h8000000000000000, 64'h4014000000000000, 64'h8000000000000000, 4'b0000);
        runOp("nan_in",    64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 4'b1000);
        runOp("inf_inf",   64'hFFF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 4'b1000);
        runOp("denorm_a",  64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000000, 4'b0000);
        runOp("denorm_b",  64'h3FF0000000000000, 64'h000FFFFFFFFFFFFF, 64'h7FF0000000000000, 4'b0100);

        // start held during DIV must be ignored: one valid, carrying the first result
        applyStimulus(64'h4029000000000000, 64'h4004000000000000);
        repeat (5) @(negedge clk);
        a     = 64'h3FF0000000000000;
        b     = 64'h4008000000000000;
        start = 1'b1;
        repeat (10) @(negedge clk);
        start     = 1'b0;
        vcount    = 0;
        first_quo = '0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                if (vcount == 0) first_quo = quo;
                vcount++;
            end
        end
        checkOutput("restart_valid_count", 64'(vcount), 64'd1);
        checkOutput("restart_quo", first_quo, 64'h4014000000000000);

        // reset in the middle of DIV aborts the operation
        applyStimulus(64'h4029000000000000, 64'h4004000000000000);
        repeat (30) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        checkOutput("abort_ready", {63'd0, ready}, 64'd1);
        checkOutput("abort_valid", {63'd0, valid}, 64'd0);
        checkOutput("abort_quo", quo, 64'd0);
        #1 nrst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        checkOutput("abort_no_valid", 64'(vcount), 64'd0);
        runOp("after_abort", 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            runRandom("rand_norm", randNormal(), randNormal());
        end
        for (int i = 0; i < 16; i++) begin
            runRandom("rand_any", randAny(), randAny());
        end

        applyStimulus(64'h4000000000000000, 64'h3FF0000000000000);
        waitResult(edges);
        checkOutput("final_latency", 64'(edges), 64'd58);
        checkOutput("final_quo", quo, 64'h4000000000000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
